// File: rtl/fft_pkg.sv
// Shared constants, FSM state encoding and delay-depth helper for the SDF FFT stage controllers.
package fft_pkg;
  localparam int FFT_N     = 32;
  localparam int FFT_LOG2N = 5;
  localparam int FFT_TW_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  function automatic int delay_depth(input int stage, input int n = FFT_N);
    return n >> stage;
  endfunction
endpackage

// File: rtl/sdf_step_cnt.sv
// Sample-index counter for one SDF stage: wraps at 2**W-1, advances on en_i, clr_i has priority.
module sdf_step_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = en_i && !clr_i && (cnt_q == '1);
endmodule

// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF stage: counts samples, decodes butterfly/twiddle controls,
// and drains the delay line after the last frame. All outputs registered.
//   state | meaning
//   IDLE  | waiting for first sample of a frame
//   FILL  | first D samples loading the delay line, no output
//   RUN   | steady streaming, one output per accepted sample
//   DRAIN | D internal steps flushing the delay line with zero input
module sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter int N     = FFT_N,
  parameter int STAGE = 1,
  parameter int TW_W  = FFT_TW_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            dl_shift,
  output logic            bf_sel,
  output logic            tw_en,
  output logic [TW_W-1:0] tw_addr,
  output logic            valid_o,
  output logic            sof_o,
  output logic            busy_o
);
  localparam int LOG2N = $clog2(N);
  localparam int D     = delay_depth(STAGE, N);
  localparam int LOG2D = $clog2(D);
  localparam bit TW_ACTIVE = (D > 1);
  localparam logic [LOG2N-1:0] LAST_K = LOG2N'(D - 1);
  localparam logic [LOG2N-1:0] OUT0   = LOG2N'(D);

  state_e           state_q, state_d;
  logic [LOG2N-1:0] cnt;
  logic [LOG2N-1:0] k;
  logic             wrap;
  logic             step, clr, drain;
  logic             boundary_q;

  logic            dl_shift_q, dl_shift_d;
  logic            bf_sel_q, bf_sel_d;
  logic            tw_en_q, tw_en_d;
  logic [TW_W-1:0] tw_addr_q, tw_addr_d;
  logic            valid_q, valid_d;
  logic            sof_q, sof_d;
  logic            busy_q, busy_d;

  sdf_step_cnt #(.W(LOG2N)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (clr),
    .en_i   (step),
    .cnt_o  (cnt),
    .wrap_o (wrap)
  );

  assign k = cnt & LAST_K;

  always_comb begin
    state_d    = state_q;
    step       = 1'b0;
    clr        = 1'b0;
    drain      = 1'b0;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    dl_shift_d = 1'b0;
    bf_sel_d   = 1'b0;
    tw_en_d    = 1'b0;
    tw_addr_d  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          step    = 1'b1;
          state_d = (D == 1) ? ST_RUN : ST_FILL;
        end
      end
      ST_FILL: begin
        if (valid_i) begin
          step = 1'b1;
          if (cnt == LAST_K) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (valid_i) begin
          step    = 1'b1;
          valid_d = 1'b1;
          sof_d   = (cnt == OUT0);
        end else if (boundary_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        step    = 1'b1;
        drain   = 1'b1;
        valid_d = 1'b1;
        if (cnt == LAST_K) begin
          state_d = ST_IDLE;
          clr     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Twiddles apply only once the delay line holds differences from a butterfly half.
    if (step) begin
      dl_shift_d = 1'b1;
      bf_sel_d   = !drain && cnt[LOG2D];
      tw_en_d    = TW_ACTIVE && !cnt[LOG2D] && (state_q == ST_RUN || state_q == ST_DRAIN);
      if (tw_en_d) tw_addr_d = TW_W'(k << (STAGE - 1));
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      boundary_q <= 1'b0;
      dl_shift_q <= 1'b0;
      bf_sel_q   <= 1'b0;
      tw_en_q    <= 1'b0;
      tw_addr_q  <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      if (step) boundary_q <= wrap;
      dl_shift_q <= dl_shift_d;
      bf_sel_q   <= bf_sel_d;
      tw_en_q    <= tw_en_d;
      tw_addr_q  <= tw_addr_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      busy_q     <= busy_d;
    end
  end

  assign dl_shift = dl_shift_q;
  assign bf_sel   = bf_sel_q;
  assign tw_en    = tw_en_q;
  assign tw_addr  = tw_addr_q;
  assign valid_o  = valid_q;
  assign sof_o    = sof_q;
  assign busy_o   = busy_q;
endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Directed bench for sdf_stage_ctrl: four instances (STAGE 1,2,3,5) each driven and checked in turn.
module tb_sdf_stage_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n    [4];
  logic       valid_i  [4];
  logic       dl_shift [4];
  logic       bf_sel   [4];
  logic       tw_en    [4];
  logic [3:0] tw_addr  [4];
  logic       valid_o  [4];
  logic       sof_o    [4];
  logic       busy_o   [4];

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  int sofcount = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sdf_stage_ctrl #(.N(32), .STAGE((g == 3) ? 5 : g + 1), .TW_W(4)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n[g]),
      .valid_i  (valid_i[g]),
      .dl_shift (dl_shift[g]),
      .bf_sel   (bf_sel[g]),
      .tw_en    (tw_en[g]),
      .tw_addr  (tw_addr[g]),
      .valid_o  (valid_o[g]),
      .sof_o    (sof_o[g]),
      .busy_o   (busy_o[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, string field, int s, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s@%0d got %0h exp %0h", tag, field, s, obs, exp);
    end
  endtask

  task automatic chk_all(int idx, string tag, int s, bit ev, bit esh, bit ebf, bit etw,
                         int eaddr, bit esof, bit ebusy);
    chk(tag, "valid_o",  s, 8'(valid_o[idx]),  8'(ev));
    chk(tag, "dl_shift", s, 8'(dl_shift[idx]), 8'(esh));
    chk(tag, "bf_sel",   s, 8'(bf_sel[idx]),   8'(ebf));
    chk(tag, "tw_en",    s, 8'(tw_en[idx]),    8'(etw));
    chk(tag, "tw_addr",  s, 8'(tw_addr[idx]),  8'(eaddr));
    chk(tag, "sof_o",    s, 8'(sof_o[idx]),    8'(esof));
    chk(tag, "busy_o",   s, 8'(busy_o[idx]),   8'(ebusy));
    if (valid_o[idx] === 1'b1) vcount++;
    if (sof_o[idx] === 1'b1) sofcount++;
  endtask

  // One accepted sample number s (1-based, continuous count) with its expected decode.
  task automatic do_step(int idx, int lg2d, int stage, int s, string tag);
    int  d, c, addr;
    bit  bf, twen;
    d = 1 << lg2d;
    c = (s - 1) % 32;
    valid_i[idx] = 1'b1;
    tick();
    bf   = bit'((c >> lg2d) & 1);
    twen = (s > d) && !bf && (d > 1);
    addr = twen ? ((c & (d - 1)) << (stage - 1)) : 0;
    chk_all(idx, tag, s, s > d, 1'b1, bf, twen, addr, (s > d) && (c == d), 1'b1);
  endtask

  task automatic stall(int idx, int n, string tag);
    valid_i[idx] = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      chk_all(idx, tag, 1000 + i, 0, 0, 0, 0, 0, 0, 1);
    end
  endtask

  task automatic drain(int idx, int lg2d, int stage, string tag);
    int d;
    d = 1 << lg2d;
    valid_i[idx] = 1'b0;
    tick();
    chk_all(idx, tag, 2000, 0, 0, 0, 0, 0, 0, 1);
    for (int c = 0; c < d; c++) begin
      tick();
      chk_all(idx, tag, 2001 + c, 1, 1, 0, d > 1, (d > 1) ? (c << (stage - 1)) : 0, 0,
              c != d - 1);
    end
    tick();
    chk_all(idx, tag, 3000, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic run_stream(int idx, int lg2d, int stage, int nsamp, int stall_at,
                            int stall_len, string tag);
    for (int s = 1; s <= nsamp; s++) begin
      do_step(idx, lg2d, stage, s, tag);
      if (s == stall_at) stall(idx, stall_len, tag);
    end
    drain(idx, lg2d, stage, tag);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_n[i]   = 1'b0;
      valid_i[i] = 1'b0;
    end
    tick();
    tick();
    for (int i = 0; i < 4; i++) chk_all(i, "reset", i, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
    tick();

    // STAGE=3 (D=4): one frame then drain
    vcount = 0;
    run_stream(2, 2, 3, 32, 0, 0, "t1");
    chk("t1", "vcount", 0, 8'(vcount), 8'd32);

    // STAGE=1 (D=16): two back-to-back frames
    vcount = 0;
    sofcount = 0;
    run_stream(0, 4, 1, 64, 0, 0, "t2");
    chk("t2", "vcount", 0, 8'(vcount), 8'd64);
    chk("t2", "sofcount", 0, 8'(sofcount), 8'd2);

    // STAGE=3 with a 3-cycle stall after sample 10
    run_stream(2, 2, 3, 32, 10, 3, "t3");

    // STAGE=5 (D=1)
    vcount = 0;
    run_stream(3, 0, 5, 32, 0, 0, "t4");
    chk("t4", "vcount", 0, 8'(vcount), 8'd32);

    // STAGE=2 (D=8): reset after sample 20, then a clean frame from FILL
    for (int s = 1; s <= 20; s++) do_step(1, 3, 2, s, "t5a");
    rst_n[1]   = 1'b0;
    valid_i[1] = 1'b1;
    tick();
    chk_all(1, "t5rst", 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n[1]   = 1'b1;
    valid_i[1] = 1'b0;
    tick();
    chk_all(1, "t5idle", 0, 0, 0, 0, 0, 0, 0, 0);
    run_stream(1, 3, 2, 32, 0, 0, "t5b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
